// File: rtl/colorclk_pkg.sv
// colorclk_pkg
//   Shared constants and types for the colour-subcarrier NCO controller:
//   increment width, the four standard increment values (PAL/NTSC at
//   140/165 MHz), default register number and wrap timeout, and the
//   controller FSM state encoding.
package colorclk_pkg;

  localparam int INC_W = 29;

  localparam logic [7:0] REG_ADDR_DEF     = 8'hF7;
  localparam int         WRAP_TIMEOUT_DEF = 1023;

  // Standard increments, indexed by {altern, mode}
  localparam logic [INC_W-1:0] INC_PAL_140  = 29'd68008027;
  localparam logic [INC_W-1:0] INC_NTSC_140 = 29'd54907245;
  localparam logic [INC_W-1:0] INC_PAL_165  = 29'd57703780;
  localparam logic [INC_W-1:0] INC_NTSC_165 = 29'd46587966;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  function automatic logic [INC_W-1:0] table_inc(input logic [1:0] sel);
    logic [INC_W-1:0] val;
    case (sel)
      2'b00:   val = INC_PAL_140;
      2'b01:   val = INC_NTSC_140;
      2'b10:   val = INC_PAL_165;
      default: val = INC_NTSC_165;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/colorclk_wrapdet.sv
// colorclk_wrapdet
//   Decides when a pending increment change may be applied: either at an
//   accumulator wrap (acc_msb falling) or after WRAP_TIMEOUT cycles spent
//   pending, so a stopped NCO (increment 0) still gets updated.
// Ports
//   clk       in   fast system clock
//   rst_n     in   asynchronous active-low reset
//   acc_msb   in   NCO accumulator bit 28
//   pend      in   controller is waiting to apply; counter runs while high
//   apply_ok  out  combinational: apply may happen at the next edge
module colorclk_wrapdet
  import colorclk_pkg::*;
#(
  parameter int WRAP_TIMEOUT = WRAP_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic acc_msb,
  input  logic pend,
  output logic apply_ok
);

  localparam int CNT_W = (WRAP_TIMEOUT < 1) ? 1 : $clog2(WRAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WRAP_TIMEOUT);

  logic             msb_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             wrap;
  logic             timeout;

  // Counter restarts from zero on every entry into the pending state,
  // because it is held clear whenever pend is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      msb_reg <= acc_msb;
      if (!pend) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_LIMIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign wrap     = msb_reg & ~acc_msb;
  assign timeout  = (cnt_reg == CNT_LIMIT);
  assign apply_ok = pend & (wrap | timeout);

endmodule

// File: rtl/colorclk_ctrl.sv
// colorclk_ctrl
//   Selects the 29-bit increment for the colour-subcarrier NCO: one of four
//   table values chosen by {altern, mode}, or a CPU-programmed custom value
//   written through a ZX-UNO register. New values are only applied at an
//   accumulator wrap (or after a timeout) so the subcarrier never glitches.
// Ports
//   clk, rst_n        fast clock, asynchronous active-low reset
//   mode, altern      table select (PAL/NTSC, 140/165 MHz), asynchronous
//   zxuno_addr        currently selected ZX-UNO register
//   regaddr_changed   pulse: zxuno_addr was just written
//   zxuno_regwr/rd    data-port strobes (multi-cycle levels)
//   din, dout, oe     CPU data in / read data / bus drive enable
//   acc_msb           NCO accumulator MSB (wrap feedback)
//   increment         increment presented to the NCO
//   inc_update        high during the cycle the new increment is loaded
//   custom_active     custom value in use
module colorclk_ctrl
  import colorclk_pkg::*;
#(
  parameter logic [7:0] REG_ADDR     = REG_ADDR_DEF,
  parameter int         WRAP_TIMEOUT = WRAP_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             altern,
  input  logic [7:0]       zxuno_addr,
  input  logic             regaddr_changed,
  input  logic             zxuno_regwr,
  input  logic             zxuno_regrd,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             oe,
  input  logic             acc_msb,
  output logic [INC_W-1:0] increment,
  output logic             inc_update,
  output logic             custom_active
);

  // ---------------- register port ----------------
  logic        addressed;
  logic        regwr_reg;
  logic        regrd_reg;
  logic [1:0]  ptr_reg;
  logic [31:0] shadow;
  logic        wr_start;
  logic        strobe_end;

  assign addressed  = (zxuno_addr == REG_ADDR);
  assign wr_start   = zxuno_regwr & ~regwr_reg & addressed;
  assign strobe_end = (regwr_reg & ~zxuno_regwr) | (regrd_reg & ~zxuno_regrd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwr_reg <= 1'b0;
      regrd_reg <= 1'b0;
      ptr_reg   <= 2'd0;
    end else begin
      regwr_reg <= zxuno_regwr;
      regrd_reg <= zxuno_regrd;
      if (regaddr_changed && addressed) begin
        ptr_reg <= 2'd0;
      end else if (addressed && strobe_end) begin
        ptr_reg <= ptr_reg + 2'd1;
      end
    end
  end

  // Shadow bytes, little-endian. Byte 3 keeps only the enable (bit 7) and
  // inc[28:24] (bits 4:0); bits 6:5 are stored as zero and read back as 0.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    localparam logic [7:0] BYTE_MASK = (gi == 3) ? 8'h9F : 8'hFF;
    logic [7:0] byte_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byte_reg <= 8'h00;
      end else if (wr_start && (ptr_reg == 2'(gi))) begin
        byte_reg <= din & BYTE_MASK;
      end
    end

    assign shadow[gi*8 +: 8] = byte_reg;
  end

  assign oe   = zxuno_regrd & addressed;
  assign dout = oe ? shadow[{ptr_reg, 3'b000} +: 8] : 8'hFF;

  // ---------------- table select synchroniser ----------------
  logic [1:0] sel_meta_reg;
  logic [1:0] sel_sync_reg;
  logic [1:0] sel_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta_reg <= 2'b00;
      sel_sync_reg <= 2'b00;
      sel_prev_reg <= 2'b00;
    end else begin
      sel_meta_reg <= {altern, mode};
      sel_sync_reg <= sel_meta_reg;
      sel_prev_reg <= sel_sync_reg;
    end
  end

  // ---------------- request / target ----------------
  logic             custom_en;
  logic             request;
  logic [INC_W-1:0] target;

  assign custom_en = shadow[31];
  assign request   = (wr_start && (ptr_reg == 2'd3)) || (sel_sync_reg != sel_prev_reg);
  // Target is evaluated at apply time, so the latest request while
  // pending is the one that takes effect.
  assign target    = custom_en ? shadow[INC_W-1:0] : table_inc(sel_sync_reg);

  // ---------------- apply FSM ----------------
  state_t state_reg;
  state_t state_next;
  logic   apply_ok;
  logic   pend;

  assign pend = (state_reg == ST_PEND);

  colorclk_wrapdet #(
    .WRAP_TIMEOUT(WRAP_TIMEOUT)
  ) u_wrapdet (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_msb (acc_msb),
    .pend    (pend),
    .apply_ok(apply_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    inc_update = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (request) state_next = ST_PEND;
      end
      ST_PEND: begin
        if (apply_ok) state_next = ST_APPLY;
      end
      ST_APPLY: begin
        inc_update = 1'b1;
        state_next = request ? ST_PEND : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      increment     <= INC_PAL_140;
      custom_active <= 1'b0;
    end else if (state_reg == ST_APPLY) begin
      increment     <= target;
      custom_active <= custom_en;
    end
  end

endmodule

// File: tb/tb_colorclk_ctrl.sv
// tb_colorclk_ctrl
//   Randomised plus directed stimulus for colorclk_ctrl, checked every cycle
//   against a behavioural model; the bench also runs its own NCO accumulator
//   from the expected increment to produce acc_msb.
module tb_colorclk_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        altern;
  logic [7:0]  zxuno_addr;
  logic        regaddr_changed;
  logic        zxuno_regwr;
  logic        zxuno_regrd;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic        acc_msb;
  logic [28:0] increment;
  logic        inc_update;
  logic        custom_active;

  colorclk_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode           (mode),
    .altern         (altern),
    .zxuno_addr     (zxuno_addr),
    .regaddr_changed(regaddr_changed),
    .zxuno_regwr    (zxuno_regwr),
    .zxuno_regrd    (zxuno_regrd),
    .din            (din),
    .dout           (dout),
    .oe             (oe),
    .acc_msb        (acc_msb),
    .increment      (increment),
    .inc_update     (inc_update),
    .custom_active  (custom_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int TIMEOUT = 1023;

  int n_vec = 0;
  int n_bad = 0;
  int upd_cnt = 0;

  // behavioural model state
  logic [28:0] m_inc;
  logic        m_cust;
  logic [7:0]  m_sh [4];
  int          m_ptr;
  logic        m_wrp, m_rdp, m_msbp;
  logic [1:0]  m_q [2];     // [0] first sync stage, [1] synchronised select
  logic [1:0]  m_seen;      // previous synchronised select
  int          m_phase;     // 0 idle, 1 waiting for wrap, 2 loading
  int          m_wait;      // cycles spent waiting
  logic [28:0] nco_acc;
  logic        freeze;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [28:0] tbl(input logic [1:0] sel);
    case (sel)
      2'b00:   return 29'd68008027;
      2'b01:   return 29'd54907245;
      2'b10:   return 29'd57703780;
      default: return 29'd46587966;
    endcase
  endfunction

  task automatic model_reset();
    m_inc = 29'd68008027;
    m_cust = 1'b0;
    for (int i = 0; i < 4; i++) m_sh[i] = 8'h00;
    m_ptr = 0;
    m_wrp = 1'b0; m_rdp = 1'b0; m_msbp = 1'b0;
    m_q[0] = 2'b00; m_q[1] = 2'b00; m_seen = 2'b00;
    m_phase = 0; m_wait = 0;
  endtask

  // One clock cycle: inputs are already driven. Checks combinational read
  // outputs, advances the model, then checks registered outputs after the edge.
  task automatic cycle();
    logic        hit, wst, req, wrap, cen;
    logic [28:0] tgt, inc_before;
    int          wp;
    #1;
    hit = (zxuno_addr == 8'hF7);
    chk("oe", oe, regrd_hit(hit));
    chk("dout", dout, regrd_hit(hit) ? m_sh[m_ptr] : 8'hFF);
    inc_before = m_inc;
    wst  = zxuno_regwr && !m_wrp && hit;
    req  = (wst && m_ptr == 3) || (m_q[1] != m_seen);
    wrap = m_msbp && !acc_msb;
    cen  = m_sh[3][7];
    tgt  = cen ? {m_sh[3][4:0], m_sh[2], m_sh[1], m_sh[0]} : tbl(m_q[1]);
    case (m_phase)
      0: if (req) begin m_phase = 1; m_wait = 0; end
      1: if (wrap || m_wait == TIMEOUT) m_phase = 2; else m_wait++;
      default: begin
        m_inc = tgt; m_cust = cen;
        m_phase = req ? 1 : 0; m_wait = 0;
      end
    endcase
    wp = m_ptr;
    if (wst) m_sh[wp] = (wp == 3) ? (din & 8'h9F) : din;
    if (regaddr_changed && hit) m_ptr = 0;
    else if (hit && ((m_wrp && !zxuno_regwr) || (m_rdp && !zxuno_regrd))) m_ptr = (m_ptr + 1) % 4;
    m_wrp = zxuno_regwr; m_rdp = zxuno_regrd; m_msbp = acc_msb;
    m_seen = m_q[1]; m_q[1] = m_q[0]; m_q[0] = {altern, mode};
    @(posedge clk); #1;
    chk("increment", increment, m_inc);
    chk("custom_active", custom_active, m_cust);
    chk("inc_update", inc_update, (m_phase == 2));
    if (inc_update) upd_cnt++;
    nco_acc = nco_acc + inc_before;
    acc_msb = freeze ? 1'b0 : nco_acc[28];
  endtask

  function automatic logic regrd_hit(input logic hit);
    return zxuno_regrd && hit;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_freeze(input logic f);
    freeze = f;
    acc_msb = f ? 1'b0 : nco_acc[28];
  endtask

  task automatic sel_reg(input logic [7:0] a);
    zxuno_addr = a; regaddr_changed = 1'b1;
    cycle();
    regaddr_changed = 1'b0;
    cycle();
  endtask

  task automatic cpu_write(input logic [7:0] b);
    zxuno_regwr = 1'b1; din = b;
    cycle(); cycle();
    zxuno_regwr = 1'b0; din = 8'($urandom);
    cycle();
  endtask

  task automatic cpu_read(input logic check, input logic [7:0] exp);
    zxuno_regrd = 1'b1;
    #1;
    if (check) chk("readback", dout, exp);
    cycle(); cycle();
    zxuno_regrd = 1'b0;
    cycle();
  endtask

  task automatic write4(input logic [31:0] v);
    for (int i = 0; i < 4; i++) cpu_write(v[i*8 +: 8]);
  endtask

  task automatic do_reset();
    zxuno_regwr = 1'b0; zxuno_regrd = 1'b0; regaddr_changed = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_increment", increment, 29'd68008027);
    chk("rst_custom", custom_active, 1'b0);
    chk("rst_inc_update", inc_update, 1'b0);
    chk("rst_oe", oe, 1'b0);
    chk("rst_dout", dout, 8'hFF);
    model_reset();
    nco_acc = '0; acc_msb = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int op;
    rst_n = 1'b0; mode = 1'b0; altern = 1'b0; zxuno_addr = 8'h00;
    regaddr_changed = 1'b0; zxuno_regwr = 1'b0; zxuno_regrd = 1'b0;
    din = 8'h00; acc_msb = 1'b0; freeze = 1'b0; nco_acc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    // 1: reset state
    chk("t1_increment", increment, 29'd68008027);
    chk("t1_custom", custom_active, 1'b0);
    chk("t1_dout", dout, 8'hFF);
    chk("t1_oe", oe, 1'b0);
    idle(10);

    // 2: NTSC select, applied at a wrap with a single update pulse
    upd_cnt = 0;
    mode = 1'b1;
    idle(40);
    chk("t2_increment", increment, 29'd54907245);
    chk("t2_pulses", upd_cnt, 1);

    // 3: custom increment 0x02000000 through the register port
    sel_reg(8'hF7);
    write4(32'h82000000);
    idle(40);
    chk("t3_increment", increment, 29'h02000000);
    chk("t3_custom", custom_active, 1'b1);
    cpu_read(1'b1, 8'h00); cpu_read(1'b1, 8'h00);
    cpu_read(1'b1, 8'h00); cpu_read(1'b1, 8'h82);

    // 4: stalled NCO, apply forced by the timeout
    set_freeze(1'b1);
    upd_cnt = 0;
    mode = 1'b0;
    idle(1000);
    chk("t4_no_early", upd_cnt, 0);
    idle(40);
    chk("t4_pulses", upd_cnt, 1);
    set_freeze(1'b0);
    idle(20);

    // 5: byte-3 write then altern toggle while pending -> one apply
    set_freeze(1'b1);
    upd_cnt = 0;
    write4(32'h82000000);
    altern = 1'b1;
    idle(5);
    set_freeze(1'b0);
    idle(60);
    chk("t5_pulses", upd_cnt, 1);
    chk("t5_increment", increment, 29'h02000000);
    chk("t5_custom", custom_active, 1'b1);
    write4(32'h02000000);
    idle(60);
    chk("t5_table", increment, 29'd57703780);
    chk("t5_custom_off", custom_active, 1'b0);

    // 6: reset while pending discards the change
    altern = 1'b0;
    idle(60);
    set_freeze(1'b1);
    write4(32'h82000000);
    idle(5);
    do_reset();
    upd_cnt = 0;
    set_freeze(1'b0);
    idle(100);
    chk("t6_no_update", upd_cnt, 0);
    chk("t6_increment", increment, 29'd68008027);

    // random traffic against the model
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: begin mode = ~mode; idle($urandom_range(1, 20)); end
        1: begin altern = ~altern; idle($urandom_range(1, 20)); end
        2: begin
          if ($urandom_range(0, 1) == 1) sel_reg(8'hF7);
          for (int k = 0; k < $urandom_range(1, 4); k++) cpu_write(8'($urandom));
          idle($urandom_range(1, 30));
        end
        3: begin
          sel_reg(8'hF7);
          for (int k = 0; k < 4; k++) cpu_read(1'b0, 8'h00);
        end
        4: begin
          sel_reg(8'h10);
          cpu_write(8'($urandom)); cpu_read(1'b0, 8'h00);
        end
        5: idle($urandom_range(1, 40));
        6: begin
          set_freeze(1'b1);
          idle($urandom_range(0, 1200));
          set_freeze(1'b0);
        end
        default: begin
          do_reset();
          idle($urandom_range(1, 10));
        end
      endcase
    end
    idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
